// File: rtl/decode_scan_if.sv
// decode_scan_if: control inputs and decoded outputs of decode_scan.
// The master drives enable/mode/select; the slave (decoder) returns o, idx and step.
interface decode_scan_if #(
  parameter int SEL_W = 3
);
  localparam int OUT_W = 2**SEL_W;

  logic             en;
  logic             mode;
  logic [SEL_W-1:0] i;
  logic [OUT_W-1:0] o;
  logic [SEL_W-1:0] idx;
  logic             step;

  modport master (
    output en, mode, i,
    input  o, idx, step
  );

  modport slave (
    input  en, mode, i,
    output o, idx, step
  );
endinterface

// File: rtl/decode_scan.sv
// decode_scan: registered binary-to-one-hot decoder with a prescaled walking-one scan mode.
// Define DECODE_SCAN_ACTIVE_LOW_EN to drive o one-cold (all-ones when idle) for common-anode displays.
module decode_scan #(
  parameter int SEL_W     = 3,
  parameter int SCAN_LAST = 7,
  parameter int PRESCALE  = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  decode_scan_if.slave bus
);
  localparam int OUT_W = 2**SEL_W;
  localparam logic [23:0]      PSC_LAST = 24'(PRESCALE - 1);
  localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(SCAN_LAST);

`ifdef DECODE_SCAN_ACTIVE_LOW_EN
  localparam logic [OUT_W-1:0] O_IDLE = {OUT_W{1'b1}};
`else
  localparam logic [OUT_W-1:0] O_IDLE = {OUT_W{1'b0}};
`endif

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIRECT = 2'd1,
    ST_SCAN   = 2'd2
  } state_t;

  generate
    if (SCAN_LAST >= OUT_W) begin : g_bad_scan_last
      $error("decode_scan: SCAN_LAST must be below OUT_W");
    end
    if (PRESCALE < 1) begin : g_bad_prescale
      $error("decode_scan: PRESCALE must be at least 1");
    end
  endgenerate

  // Output polarity is folded in here so the register itself holds the pin value.
  function automatic logic [OUT_W-1:0] drive_o(input logic [SEL_W-1:0] sel);
    logic [OUT_W-1:0] hot;
    hot = {{(OUT_W-1){1'b0}}, 1'b1} << sel;
`ifdef DECODE_SCAN_ACTIVE_LOW_EN
    drive_o = ~hot;
`else
    drive_o = hot;
`endif
  endfunction

  state_t           r_state;
  logic [OUT_W-1:0] r_o;
  logic [SEL_W-1:0] r_idx;
  logic             r_step;
  logic [23:0]      r_psc;

  state_t           w_state_nxt;
  logic [OUT_W-1:0] w_o_nxt;
  logic [SEL_W-1:0] w_idx_nxt;
  logic             w_step_nxt;
  logic [23:0]      w_psc_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_o     <= O_IDLE;
      r_idx   <= {SEL_W{1'b0}};
      r_step  <= 1'b0;
      r_psc   <= 24'd0;
    end else begin
      r_state <= w_state_nxt;
      r_o     <= w_o_nxt;
      r_idx   <= w_idx_nxt;
      r_step  <= w_step_nxt;
      r_psc   <= w_psc_nxt;
    end
  end

  // en has priority over mode in every state.
  always_comb begin
    w_state_nxt = ST_IDLE;
    case (r_state)
      ST_IDLE, ST_DIRECT, ST_SCAN: begin
        if (!bus.en) begin
          w_state_nxt = ST_IDLE;
        end else if (bus.mode) begin
          w_state_nxt = ST_SCAN;
        end else begin
          w_state_nxt = ST_DIRECT;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_o_nxt    = O_IDLE;
    w_idx_nxt  = {SEL_W{1'b0}};
    w_step_nxt = 1'b0;
    w_psc_nxt  = 24'd0;
    case (w_state_nxt)
      ST_IDLE: begin
        w_o_nxt = O_IDLE;
      end
      ST_DIRECT: begin
        w_o_nxt   = drive_o(bus.i);
        w_idx_nxt = bus.i;
      end
      ST_SCAN: begin
        // Any entry into scan restarts the walk at index 0.
        if (r_state != ST_SCAN) begin
          w_idx_nxt = {SEL_W{1'b0}};
          w_o_nxt   = drive_o({SEL_W{1'b0}});
        end else if (r_psc == PSC_LAST) begin
          if (r_idx == IDX_LAST) begin
            w_idx_nxt = {SEL_W{1'b0}};
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
          w_o_nxt    = drive_o(w_idx_nxt);
          w_step_nxt = 1'b1;
        end else begin
          w_idx_nxt = r_idx;
          w_o_nxt   = drive_o(r_idx);
          w_psc_nxt = r_psc + 24'd1;
        end
      end
      default: begin
        w_o_nxt = O_IDLE;
      end
    endcase
  end

  assign bus.o    = r_o;
  assign bus.idx  = r_idx;
  assign bus.step = r_step;
endmodule

// File: tb/tb_decode_scan.sv
// tb_decode_scan: directed stimulus with a queued scoreboard for two decode_scan configurations.
// Instance a uses defaults (SCAN_LAST=7, PRESCALE=4); instance b uses SCAN_LAST=3, PRESCALE=1.
module tb_decode_scan;
  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  decode_scan_if #(.SEL_W(3)) bus_a ();
  decode_scan_if #(.SEL_W(3)) bus_b ();

  decode_scan #(.SEL_W(3), .SCAN_LAST(7), .PRESCALE(4)) u_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  decode_scan #(.SEL_W(3), .SCAN_LAST(3), .PRESCALE(1)) u_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  typedef struct {
    int         dut;
    logic [7:0] o;
    logic [2:0] idx;
    logic       step;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   step_cnt = 0;

  exp_t       mon_e;
  logic [7:0] mon_o;
  logic [2:0] mon_idx;
  logic       mon_step;

  logic [7:0] dir_o [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

  function automatic logic [7:0] pol(input logic [7:0] hot);
`ifdef DECODE_SCAN_ACTIVE_LOW_EN
    return ~hot;
`else
    return hot;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: outputs settle on the rising edge, so sample 1 time unit later.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      if (mon_e.dut == 0) begin
        mon_o = bus_a.o; mon_idx = bus_a.idx; mon_step = bus_a.step;
      end else begin
        mon_o = bus_b.o; mon_idx = bus_b.idx; mon_step = bus_b.step;
      end
      check({mon_e.tag, "_o"},    {24'd0, mon_o},    {24'd0, mon_e.o});
      check({mon_e.tag, "_idx"},  {29'd0, mon_idx},  {29'd0, mon_e.idx});
      check({mon_e.tag, "_step"}, {31'd0, mon_step}, {31'd0, mon_e.step});
      if (mon_e.dut == 0 && mon_e.tag == "scan" && mon_step) begin
        step_cnt++;
      end
    end
  end

  task automatic cyc_a(input logic en, input logic mode, input logic [2:0] sel,
                       input logic [7:0] eo, input logic [2:0] eidx, input logic estep,
                       input string tag);
    bus_a.en = en; bus_a.mode = mode; bus_a.i = sel;
    sb.push_back('{0, pol(eo), eidx, estep, tag});
    @(negedge clk);
  endtask

  task automatic cyc_b(input logic en, input logic mode, input logic [2:0] sel,
                       input logic [7:0] eo, input logic [2:0] eidx, input logic estep,
                       input string tag);
    bus_b.en = en; bus_b.mode = mode; bus_b.i = sel;
    sb.push_back('{1, pol(eo), eidx, estep, tag});
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    bus_a.en = 1'b0; bus_a.mode = 1'b0; bus_a.i = 3'd0;
    bus_b.en = 1'b0; bus_b.mode = 1'b0; bus_b.i = 3'd0;
    repeat (2) @(negedge clk);
    check("reset_init_o",    {24'd0, bus_a.o},    {24'd0, pol(8'h00)});
    check("reset_init_step", {31'd0, bus_a.step}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Direct sweep: one-cycle latency, step never asserted.
    for (int k = 0; k < 8; k++) begin
      cyc_a(1'b1, 1'b0, 3'(k), dir_o[k], 3'(k), 1'b0, "direct");
    end

    // Asynchronous reset mid-cycle while o = 0x80.
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_o",    {24'd0, bus_a.o},    {24'd0, pol(8'h00)});
    check("async_rst_idx",  {29'd0, bus_a.idx},  32'd0);
    check("async_rst_step", {31'd0, bus_a.step}, 32'd0);
    bus_a.en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Scan with defaults: advance every 4 cycles, wrap 0x80 -> 0x01 after 32, run on to idx 5.
    step_cnt = 0;
    for (int n = 0; n <= 52; n++) begin
      cyc_a(1'b1, 1'b1, 3'd0, 8'h01 << ((n / 4) % 8), 3'((n / 4) % 8),
            (n > 0) && (n % 4 == 0), (n <= 32) ? "scan" : "scan_run");
    end
    check("scan_step_count", step_cnt, 32'd8);

    // Disruptions mid-scan at idx 5.
    cyc_a(1'b1, 1'b0, 3'd2, 8'h04, 3'd2, 1'b0, "mid_direct");
    cyc_a(1'b1, 1'b1, 3'd2, 8'h01, 3'd0, 1'b0, "rescan");
    cyc_a(1'b1, 1'b1, 3'd2, 8'h01, 3'd0, 1'b0, "rescan_hold");
    cyc_a(1'b0, 1'b0, 3'd2, 8'h00, 3'd0, 1'b0, "en_drop");
    cyc_a(1'b0, 1'b1, 3'd5, 8'h00, 3'd0, 1'b0, "idle_hold");

    // Short scan, PRESCALE=1: moves every cycle, step stays high after entry.
    for (int n = 0; n <= 8; n++) begin
      cyc_b(1'b1, 1'b1, 3'd0, 8'h01 << (n % 4), 3'(n % 4), n > 0, "scan_fast");
    end
    cyc_b(1'b1, 1'b0, 3'd6, 8'h40, 3'd6, 1'b0, "b_direct_beyond_last");
    cyc_b(1'b0, 1'b0, 3'd0, 8'h00, 3'd0, 1'b0, "b_idle");

    @(negedge clk);
    check("scoreboard_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
